// File: rtl/irqgen_latency_monitor.sv
// IRQ latency monitor: measures cycles from an IRQ rise to its acknowledge,
// keeps min/max/last/count statistics and queues each sample in a FWFT FIFO.
// Optional build macro IRQGEN_LATMON_SUM_EN adds a saturating 32-bit latency sum.
module irqgen_latency_monitor #(
    parameter int unsigned C_AMOUNT_OF_IRQLINES = 16,
    parameter int unsigned C_WIDTH_OF_LATENCY   = 16,
    parameter int unsigned C_FIFO_DEPTH_LOG2    = 4
) (
    input  logic                            ACLK,
    input  logic                            ARESET,
    input  logic [C_AMOUNT_OF_IRQLINES-1:0] irq_out,
    input  logic [4:0]                      irq_handled,
    input  logic                            clear,
    input  logic                            lat_rd_en,
    output logic [4+C_WIDTH_OF_LATENCY-1:0] lat_rd_data,
    output logic                            lat_empty,
    output logic                            lat_full,
    output logic                            lat_overflow,
    output logic [C_FIFO_DEPTH_LOG2:0]      lat_level,
    output logic [C_WIDTH_OF_LATENCY-1:0]   lat_last,
    output logic [C_WIDTH_OF_LATENCY-1:0]   lat_min,
    output logic [C_WIDTH_OF_LATENCY-1:0]   lat_max,
    output logic [15:0]                     done_count,
    output logic [15:0]                     stray_count,
    output logic [15:0]                     abort_count,
    output logic [31:0]                     lat_sum
);

    localparam int unsigned LW    = C_WIDTH_OF_LATENCY;
    localparam int unsigned PW    = C_FIFO_DEPTH_LOG2;
    localparam int unsigned Depth = 1 << PW;

    typedef enum logic [0:0] {StIdle, StMeasure} state_e;

    state_e                          state_q, state_d;
    logic [C_AMOUNT_OF_IRQLINES-1:0] irq_prev_q, rise;
    logic [3:0]                      cur_line_q, cur_line_d, rise_idx;
    logic [LW-1:0]                   cnt_q, cnt_d;
    logic [15:0]                     irq_ext;
    logic                            ack, line_live, done, stray, abort, rst;

    logic [4+LW-1:0] mem_q [Depth];
    logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [PW:0]     level_q, level_d;
    logic            empty_q, full_q, overflow_q, push_ok, pop;

    logic [LW-1:0]   last_q, min_q, max_q;
    logic [15:0]     done_cnt_q, stray_cnt_q, abort_cnt_q;

    // clear behaves exactly like reset
    assign rst       = ARESET | clear;
    assign rise      = irq_out & ~irq_prev_q;
    assign ack       = irq_handled[0];
    // zero-extend so a 4-bit line index is always in range
    assign irq_ext   = 16'(irq_out);
    assign line_live = irq_ext[cur_line_q];

    // Lowest-index rising line wins
    always_comb begin
        rise_idx = '0;
        for (int i = int'(C_AMOUNT_OF_IRQLINES) - 1; i >= 0; i--) begin
            if (rise[i]) rise_idx = 4'(i);
        end
    end

    // FSM next state and measurement events
    always_comb begin
        state_d    = state_q;
        cur_line_d = cur_line_q;
        cnt_d      = cnt_q;
        done       = 1'b0;
        stray      = 1'b0;
        abort      = 1'b0;
        unique case (state_q)
            StIdle: begin
                stray = ack;
                if (rise != '0) begin
                    cur_line_d = rise_idx;
                    cnt_d      = LW'(1);
                    state_d    = StMeasure;
                end
            end
            StMeasure: begin
                if (ack && (irq_handled[4:1] == cur_line_q)) begin
                    done    = 1'b1;
                    state_d = StIdle;
                end else if (ack) begin
                    // wrong-line ack: time still passes for the pending IRQ
                    stray = 1'b1;
                    if (cnt_q != {LW{1'b1}}) cnt_d = cnt_q + LW'(1);
                end else if (!line_live) begin
                    abort   = 1'b1;
                    state_d = StIdle;
                end else if (cnt_q != {LW{1'b1}}) begin
                    cnt_d = cnt_q + LW'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // FSM, edge-detect and counter registers
    always_ff @(posedge ACLK) begin
        if (rst) begin
            state_q    <= StIdle;
            irq_prev_q <= '0;
            cur_line_q <= '0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            irq_prev_q <= irq_out;
            cur_line_q <= cur_line_d;
            cnt_q      <= cnt_d;
        end
    end

    // Statistics and saturating event counters
    always_ff @(posedge ACLK) begin
        if (rst) begin
            last_q      <= '0;
            min_q       <= '1;
            max_q       <= '0;
            done_cnt_q  <= '0;
            stray_cnt_q <= '0;
            abort_cnt_q <= '0;
        end else begin
            if (done) begin
                last_q <= cnt_q;
                if (cnt_q < min_q) min_q <= cnt_q;
                if (cnt_q > max_q) max_q <= cnt_q;
                if (done_cnt_q != 16'hFFFF) done_cnt_q <= done_cnt_q + 16'd1;
            end
            if (stray && stray_cnt_q != 16'hFFFF) stray_cnt_q <= stray_cnt_q + 16'd1;
            if (abort && abort_cnt_q != 16'hFFFF) abort_cnt_q <= abort_cnt_q + 16'd1;
        end
    end

    // FIFO occupancy: simultaneous push and pop is always accepted, even when full
    assign pop     = lat_rd_en & ~empty_q;
    assign push_ok = done & (~full_q | pop);

    always_comb begin
        level_d = level_q;
        if (push_ok && !pop) level_d = level_q + (PW+1)'(1);
        else if (pop && !push_ok) level_d = level_q - (PW+1)'(1);
    end

    // FIFO pointers, registered flags and sticky overflow
    always_ff @(posedge ACLK) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            empty_q    <= 1'b1;
            full_q     <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (pop)     rd_ptr_q <= rd_ptr_q + PW'(1);
            level_q <= level_d;
            empty_q <= (level_d == '0);
            full_q  <= (level_d == (PW+1)'(Depth));
            if (done && full_q && !pop) overflow_q <= 1'b1;
        end
    end

    // FIFO storage; contents are don't-care until pointed at
    always_ff @(posedge ACLK) begin
        if (push_ok) mem_q[wr_ptr_q] <= {cur_line_q, cnt_q};
    end

`ifdef IRQGEN_LATMON_SUM_EN
    logic [31:0] sum_q;

    // Saturating accumulator of completed latencies
    always_ff @(posedge ACLK) begin
        if (rst) begin
            sum_q <= '0;
        end else if (done) begin
            if (sum_q > (32'hFFFF_FFFF - 32'(cnt_q))) sum_q <= 32'hFFFF_FFFF;
            else sum_q <= sum_q + 32'(cnt_q);
        end
    end

    assign lat_sum = sum_q;
`else
    assign lat_sum = '0;
`endif

    assign lat_rd_data  = empty_q ? '0 : mem_q[rd_ptr_q];
    assign lat_empty    = empty_q;
    assign lat_full     = full_q;
    assign lat_overflow = overflow_q;
    assign lat_level    = level_q;
    assign lat_last     = last_q;
    assign lat_min      = min_q;
    assign lat_max      = max_q;
    assign done_count   = done_cnt_q;
    assign stray_count  = stray_cnt_q;
    assign abort_count  = abort_cnt_q;

endmodule

// File: doc/irqgen_latency_monitor.md
Name: irqgen_latency_monitor

Overview:
- Sits directly downstream of the IRQ generator controller.
- Consumes the controller's registered `irq_out` vector and the same `irq_handled` acknowledge bus that software drives into the controller.
- Measures the cycles from each IRQ assertion to its acknowledge and keeps min/max/last/count statistics.
- Pushes every completed sample into a small first-word-fall-through FIFO, which the register interface drains for software readout.

Parameters:
- C_AMOUNT_OF_IRQLINES, 16, width of `irq_out`; max 16 (line index is 4 bits).
- C_WIDTH_OF_LATENCY, 16, width of the latency counter and of every latency statistic.
- C_FIFO_DEPTH_LOG2, 4, log2 of the sample FIFO depth (default 16 entries).

Ports:
- ACLK  in  1  system clock.
- ARESET  in  1  synchronous active-high reset.
- irq_out  in  C_AMOUNT_OF_IRQLINES  IRQ lines from the generator.
- irq_handled  in  5  bit0 = ack strobe, [4:1] = acknowledged line.
- clear  in  1  synchronous clear of statistics, FIFO and FSM.
- lat_rd_en  in  1  pop FIFO head.
- lat_rd_data  out  4+C_WIDTH_OF_LATENCY  FIFO head: {line[3:0], latency}.
- lat_empty  out  1  FIFO empty.
- lat_full  out  1  FIFO full.
- lat_overflow  out  1  sticky: a sample was dropped.
- lat_level  out  C_FIFO_DEPTH_LOG2+1  FIFO occupancy.
- lat_last  out  C_WIDTH_OF_LATENCY  most recent latency.
- lat_min  out  C_WIDTH_OF_LATENCY  minimum latency.
- lat_max  out  C_WIDTH_OF_LATENCY  maximum latency.
- done_count  out  16  completed measurements, saturating.
- stray_count  out  16  unmatched acks, saturating.
- abort_count  out  16  IRQs dropped without ack, saturating.
- lat_sum  out  32  latency sum (see Optional Feature).

Behaviour:
- Clock and reset: single clock ACLK; ARESET is synchronous active-high.
- Reset values: FSM = IDLE; FIFO empty; `irq_prev` = 0; `lat_rd_data` = 0; `lat_empty` = 1; `lat_full` = 0; `lat_overflow` = 0; `lat_level` = 0; `lat_last` = 0; `lat_min` = all ones; `lat_max` = 0; all counts = 0; `lat_sum` = 0.
- `clear` has the same effect as ARESET. It has priority over every other event in the same cycle.
- Edge detect: `irq_prev` registers `irq_out` each cycle; `rise = irq_out & ~irq_prev`.
- FSM state IDLE:
  - If `rise != 0`, capture the lowest set index as `cur_line`, load `cnt = 1`, go to MEASURE.
  - An ack arriving in IDLE increments `stray_count`.
- FSM state MEASURE:
  - Ack with `irq_handled[0] = 1` and `irq_handled[4:1] == cur_line`:
    - record sample `cnt`;
    - `lat_last = cnt`;
    - `lat_min = min(lat_min, cnt)`;
    - `lat_max = max(lat_max, cnt)`;
    - `done_count + 1`;
    - push `{cur_line, cnt}`;
    - go to IDLE.
  - Ack on any other line: `stray_count + 1`; stay in MEASURE.
  - No matching ack and `irq_out[cur_line] == 0` (line dropped without ack): `abort_count + 1`; go to IDLE; no sample recorded.
  - Otherwise `cnt = cnt + 1`, saturating at all ones (no wrap).
- Latency meaning: an ack sampled in the first cycle after entering MEASURE records 1.
- A rise on another line during MEASURE is ignored. It is not queued.
- Completion and a new rise in the same cycle: the new rise is not captured, because `irq_prev` already shows it high on the next cycle.
- FIFO behaviour:
  - First-word-fall-through: `lat_rd_data` shows the head whenever `lat_empty = 0`.
  - `lat_rd_en` pops the head; it is ignored when empty.
  - Push when full without a simultaneous pop: sample dropped, `lat_overflow` set. Statistics are still updated.
  - Push and pop in the same cycle: both occur, level unchanged, no overflow, even when full.
  - Read and write pointers wrap modulo the depth.
- Flags `lat_empty`, `lat_full` and `lat_level` are registered and reflect the post-update occupancy one cycle after the event.
- Statistic and count outputs are registered and update one cycle after the ack is sampled.

Optional Feature:
- Macro: IRQGEN_LATMON_SUM_EN.
- Defined: `lat_sum` is a 32-bit accumulator. On each completion it adds `cnt`, saturating at 0xFFFFFFFF. It resets on ARESET or `clear`.
- Undefined: no accumulator is built; `lat_sum` is tied to 0.

Test Plan:
- Reset, then rise on `irq_out[3]` at cycle 0, ack `{line=3, bit0=1}` sampled at cycle 10 -> one cycle later: `lat_last = 10`, `lat_min = 10`, `lat_max = 10`, `done_count = 1`, `lat_rd_data = {3, 10}`, `lat_level = 1`.
- Three IRQs on line 2 with latencies 5, 20, 8, then pop three times -> `lat_min = 5`, `lat_max = 20`, `done_count = 3`; FIFO returns 5, 20, 8 in order, then `lat_empty = 1`; `lat_sum = 33` with the macro defined, 0 without.
- 17 completions with no reads (depth 16) -> `lat_full = 1`, `lat_overflow = 1`, `lat_level = 16`, `done_count = 17`; the 17th sample is absent from the FIFO. Then push and pop in the same cycle -> `lat_level` stays 16, the popped head is the first sample.
- In MEASURE on line 1, ack line 4 -> `stray_count = 1`, FSM stays in MEASURE. Then drop `irq_out[1]` without an ack -> `abort_count = 1`, no sample pushed, FSM in IDLE.
- Hold `irq_out[0]` with no ack for `2^16 + 5` cycles, then ack -> recorded latency = 0xFFFF (saturated).
- `clear` asserted in the same cycle as a matching ack, and mid-measurement -> no sample recorded, all statistics at reset values, `lat_min = 0xFFFF`, FSM in IDLE.
